shift_exec_ctrl: RTL and testbench



---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_exec_ctrl_if.sv | 37 +++
 rtl/bit_reverse32.sv | 18 +
 rtl/shift_exec_ctrl.sv | 159 +++++++++++++++
 tb/tb_shift_exec_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared constants and encodings for the shift execute-stage controller.
package shift_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHW   = 5;
  localparam int unsigned TAGW  = 5;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SRA = 2'b01,
    OP_SLL = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_ROT2  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/shift_exec_ctrl_if.sv
// Request, result and external-shifter signals of the shift controller.
//   in_*   : issue-side request (valid/ready)
//   out_*  : writeback-side result (valid/ready)
//   shf_*  : connection to the external combinational right shifter
interface shift_exec_ctrl_if;
  import shift_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [SHW-1:0]    in_sha;
  logic [1:0]        in_op;
  logic [TAGW-1:0]   in_tag;

  logic [WIDTH-1:0]  shf_in;
  logic [SHW-1:0]    shf_sha;
  logic [WIDTH-1:0]  shf_out;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_result;
  logic [TAGW-1:0]   out_tag;
  logic              out_zero;

  // Controller side
  modport slave (
    input  in_valid, in_data, in_sha, in_op, in_tag, shf_out, out_ready,
    output in_ready, shf_in, shf_sha, out_valid, out_result, out_tag, out_zero
  );

  // Issue / writeback / shifter side
  modport master (
    output in_valid, in_data, in_sha, in_op, in_tag, shf_out, out_ready,
    input  in_ready, shf_in, shf_sha, out_valid, out_result, out_tag, out_zero
  );

endinterface

// File: rtl/bit_reverse32.sv
// Combinational 32-bit bit reversal.
//   data_i : input word
//   data_o : data_o[i] = data_i[31-i]
module bit_reverse32
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      data_o[i] = data_i[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/shift_exec_ctrl.sv
// Execute-stage controller building SRL/SRA/SLL/ROR around an external
// right-only shifter. ROR with a non-zero amount takes two shifter passes.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous abort of any in-flight operation
//   bus        : request, result and shifter connection (slave side)
module shift_exec_ctrl
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  shift_exec_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [SHW-1:0]    sha_q, sha_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  partial_q, partial_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              valid_q, valid_d;
  logic              zero_q, zero_d;

  logic [WIDTH-1:0]  data_rev;
  logic [WIDTH-1:0]  shf_out_rev;
  logic [WIDTH-1:0]  shf_in_c;
  logic [SHW-1:0]    shf_sha_c;
  logic [WIDTH-1:0]  pass_res_c;
  logic              in_ready_c;
  logic              accept_c;

  bit_reverse32 u_rev_in  (.data_i(data_q),      .data_o(data_rev));
  bit_reverse32 u_rev_out (.data_i(bus.shf_out), .data_o(shf_out_rev));

  // Reset is folded in so the issue path never sees ready during reset
  assign in_ready_c = rst_n && !flush &&
                      ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));
  assign accept_c   = bus.in_valid && in_ready_c;

  // Shifter operand/amount per pass; SLL and the ROR left half use reversed data
  always_comb begin
    shf_in_c  = '0;
    shf_sha_c = '0;
    case (state_q)
      S_SHIFT: begin
        shf_sha_c = sha_q;
        case (op_q)
          OP_SRA:  shf_in_c = data_q[WIDTH-1] ? ~data_q : data_q;
          OP_SLL:  shf_in_c = data_rev;
          default: shf_in_c = data_q;
        endcase
      end
      S_ROT2: begin
        shf_in_c  = data_rev;
        shf_sha_c = ~sha_q + SHW'(1);
      end
      default: ;
    endcase
  end

  // First-pass result; SRA inverts back, SLL reverses back, ROR by 0 is identity
  always_comb begin
    pass_res_c = bus.shf_out;
    case (op_q)
      OP_SRA:  pass_res_c = data_q[WIDTH-1] ? ~bus.shf_out : bus.shf_out;
      OP_SLL:  pass_res_c = shf_out_rev;
      OP_ROR:  pass_res_c = data_q;
      default: pass_res_c = bus.shf_out;
    endcase
  end

  // Next-state and register update logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sha_d     = sha_q;
    tag_d     = tag_q;
    data_d    = data_q;
    partial_d = partial_q;
    result_d  = result_q;
    valid_d   = valid_q;
    zero_d    = zero_q;

    if (flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_SHIFT: begin
          if ((op_q == OP_ROR) && (sha_q != '0)) begin
            partial_d = bus.shf_out;
            state_d   = S_ROT2;
          end else begin
            result_d = pass_res_c;
            zero_d   = (pass_res_c == '0);
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_ROT2: begin
          result_d = partial_q | shf_out_rev;
          zero_d   = ((partial_q | shf_out_rev) == '0);
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase

      // Accept from IDLE, or from DONE while retiring the held result
      if (accept_c) begin
        op_d    = op_e'(bus.in_op);
        sha_d   = bus.in_sha;
        tag_d   = bus.in_tag;
        data_d  = bus.in_data;
        state_d = S_SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_SRL;
      sha_q     <= '0;
      tag_q     <= '0;
      data_q    <= '0;
      partial_q <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sha_q     <= sha_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      partial_q <= partial_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.shf_in     = shf_in_c;
  assign bus.shf_sha    = shf_sha_c;
  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_tag    = tag_q;
  assign bus.out_zero   = zero_q;

endmodule

// File: tb/tb_shift_exec_ctrl.sv
// Self-checking bench for shift_exec_ctrl: directed table, random ops
// against an arithmetic reference, and multi-cycle corner sequences.
module tb_shift_exec_ctrl;

  logic clk;
  logic rst_n;
  logic flush;

  shift_exec_ctrl_if bus ();

  // Behavioural stand-in for the external right shifter
  assign bus.shf_out = bus.shf_in >> bus.shf_sha;

  shift_exec_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  sha;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain shift/rotate arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                        input logic [4:0] s);
    logic [63:0] dd;
    case (op)
      2'd0:    return d >> s;
      2'd1:    return 32'($signed(d) >>> s);
      2'd2:    return d << s;
      default: begin
        dd = {d, d} >> s;
        return dd[31:0];
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [4:0] s);
    return ((op == 2'd3) && (s != 5'd0)) ? 2 : 1;
  endfunction

  // Issue one request and wait (bounded) for out_valid; optionally retire it
  task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                        input logic [4:0] t, input bit retire,
                        output logic [31:0] r, output logic [4:0] rt,
                        output logic rz, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_sha   = s;
    bus.in_tag   = t;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 6) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
    if (!bus.out_valid) lat = 99;
    r  = bus.out_result;
    rt = bus.out_tag;
    rz = bus.out_zero;
    if (retire) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
    end
  endtask

  vec_t        tbl[8];
  logic [31:0] r;
  logic [4:0]  rt;
  logic        rz;
  int          lat;
  logic [31:0] held_r;
  logic [4:0]  held_t;
  logic        seen_valid;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'd0;
    bus.in_data   = '0;
    bus.in_sha    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    tbl[0] = '{2'd0, 32'h8000_0000, 5'd4,  5'd3,  32'h0800_0000, 1};
    tbl[1] = '{2'd1, 32'h8000_0000, 5'd4,  5'd17, 32'hF800_0000, 1};
    tbl[2] = '{2'd1, 32'h7FFF_FFFF, 5'd31, 5'd1,  32'h0000_0000, 1};
    tbl[3] = '{2'd2, 32'h0000_0001, 5'd31, 5'd30, 32'h8000_0000, 1};
    tbl[4] = '{2'd2, 32'hDEAD_BEEF, 5'd0,  5'd5,  32'hDEAD_BEEF, 1};
    tbl[5] = '{2'd3, 32'h1234_5678, 5'd8,  5'd31, 32'h7812_3456, 2};
    tbl[6] = '{2'd3, 32'hA5A5_A5A5, 5'd0,  5'd12, 32'hA5A5_A5A5, 1};
    tbl[7] = '{2'd3, 32'h0000_0001, 5'd1,  5'd8,  32'h8000_0000, 2};

    #12;
    check("reset_out_valid",  32'(bus.out_valid),  32'd0);
    check("reset_out_result", bus.out_result,      32'd0);
    check("reset_in_ready",   32'(bus.in_ready),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].op, tbl[i].data, tbl[i].sha, tbl[i].tag, 1'b1, r, rt, rz, lat);
      check($sformatf("tbl%0d_result", i), r, tbl[i].exp);
      check($sformatf("tbl%0d_tag", i), 32'(rt), 32'(tbl[i].tag));
      check($sformatf("tbl%0d_zero", i), 32'(rz), 32'(tbl[i].exp == 32'd0));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Random operations against the reference
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] d;
      logic [4:0]  s;
      logic [4:0]  t;
      logic [31:0] e;
      op = 2'($urandom_range(0, 3));
      d  = (i % 5 == 0) ? 32'd0 : $urandom;
      s  = 5'($urandom_range(0, 31));
      t  = 5'($urandom_range(0, 31));
      e  = model(op, d, s);
      run_op(op, d, s, t, 1'b1, r, rt, rz, lat);
      check($sformatf("rnd%0d_result", i), r, e);
      check($sformatf("rnd%0d_tag", i), 32'(rt), 32'(t));
      check($sformatf("rnd%0d_zero", i), 32'(rz), 32'(e == 32'd0));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(model_lat(op, s)));
    end

    // Backpressure: result held, no acceptance, then retire+accept on one edge
    run_op(2'd0, 32'hCAFE_F00D, 5'd4, 5'd7, 1'b0, held_r, held_t, rz, lat);
    check("bp_first_result", held_r, 32'h0CAF_EF00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_op    = 2'd2;
      bus.in_data  = 32'h0000_0001;
      bus.in_sha   = 5'd3;
      bus.in_tag   = 5'd9;
      #1;
      check($sformatf("bp%0d_result", c), bus.out_result, 32'h0CAF_EF00);
      check($sformatf("bp%0d_tag", c), 32'(bus.out_tag), 32'd7);
      check($sformatf("bp%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1 check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_retired_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_new_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_new_result", bus.out_result, 32'h0000_0008);
    check("bp_new_tag", 32'(bus.out_tag), 32'd9);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;

    // flush while in the second ROR pass
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 2'd3;
    bus.in_data  = 32'h1234_5678;
    bus.in_sha   = 5'd8;
    bus.in_tag   = 5'd4;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    seen_valid = bus.out_valid;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 seen_valid = seen_valid | bus.out_valid;
    end
    check("flush_rot2_no_valid", 32'(seen_valid), 32'd0);
    check("flush_rot2_idle_ready", 32'(bus.in_ready), 32'd1);

    // Reset pulse during SHIFT (held result is non-zero beforehand)
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 2'd0;
    bus.in_data  = 32'hFFFF_0000;
    bus.in_sha   = 5'd1;
    bus.in_tag   = 5'd21;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid",  32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result,     32'd0);
    check("rst_out_tag",    32'(bus.out_tag),   32'd0);
    check("rst_out_zero",   32'(bus.out_zero),  32'd0);
    check("rst_in_ready",   32'(bus.in_ready),  32'd0);
    check("rst_shf_in",     bus.shf_in,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 seen_valid = seen_valid | bus.out_valid;
    end
    check("rst_dropped_no_valid", 32'(seen_valid), 32'd0);

    // flush together with in_valid: request must not be accepted
    @(negedge clk);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = 2'd0;
    bus.in_data  = 32'h0000_00F0;
    bus.in_sha   = 5'd4;
    bus.in_tag   = 5'd2;
    #1 check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 seen_valid = seen_valid | bus.out_valid;
    end
    check("flush_req_not_accepted", 32'(seen_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
